// File: rtl/bp_fe_ras_stack_pkg.sv
// Shared types and helpers for the frontend return address stack.
// Operation decode and derived-width helpers used by the stack and its pointer unit.
package bp_fe_ras_stack_pkg;

    localparam int unsigned RAS_VADDR_W_DEF = 39;
    localparam int unsigned RAS_ELS_DEF     = 8;

    typedef enum logic [1:0] {
        RAS_OP_NONE = 2'b00,
        RAS_OP_POP  = 2'b01,
        RAS_OP_PUSH = 2'b10,
        RAS_OP_SWAP = 2'b11
    } ras_op_e;

    // Pointer width that never collapses to zero bits for a single-entry stack
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic ras_op_e ras_op_decode(input logic call, input logic ret);
        return ras_op_e'({call, ret});
    endfunction

endpackage

// File: rtl/bp_fe_ras_ptr.sv
// Top-of-stack pointer and occupancy tracking for the return address stack.
// Applies restore > swap > push > pop priority and produces the entry write strobe.
module bp_fe_ras_ptr
    import bp_fe_ras_stack_pkg::*;
#(
    parameter int unsigned ras_els_p    = RAS_ELS_DEF,
    parameter int unsigned ptr_width_lp = safe_clog2(ras_els_p),
    parameter int unsigned cnt_width_lp = $clog2(ras_els_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    call_i,
    input  logic                    return_i,
    input  logic                    restore_v_i,
    input  logic [ptr_width_lp-1:0] restore_tos_i,
    input  logic [cnt_width_lp-1:0] restore_count_i,
    output logic [ptr_width_lp-1:0] tos_o,
    output logic [cnt_width_lp-1:0] count_o,
    output logic [ptr_width_lp-1:0] wr_idx_c_o,
    output logic                    wr_en_c_o,
    output logic                    overflow_o
);

    // Power-of-two depth: masking gives mod arithmetic, and pins tos to 0 when depth is 1
    localparam logic [ptr_width_lp-1:0] ptr_mask_lp = ptr_width_lp'(ras_els_p - 1);
    localparam logic [cnt_width_lp-1:0] cnt_max_lp  = cnt_width_lp'(ras_els_p);

    logic [ptr_width_lp-1:0] r_tos, w_tos_n, w_tos_inc, w_tos_dec;
    logic [cnt_width_lp-1:0] r_count, w_count_n;
    logic                    r_overflow, w_overflow_n;
    ras_op_e                 w_op;

    assign w_tos_inc = (r_tos + ptr_width_lp'(1)) & ptr_mask_lp;
    assign w_tos_dec = (r_tos - ptr_width_lp'(1)) & ptr_mask_lp;
    assign w_op      = ras_op_decode(call_i, return_i);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_tos      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_tos      <= w_tos_n;
            r_count    <= w_count_n;
            r_overflow <= w_overflow_n;
        end
    end

    always_comb begin
        w_tos_n      = r_tos;
        w_count_n    = r_count;
        w_overflow_n = 1'b0;
        wr_en_c_o    = 1'b0;
        wr_idx_c_o   = w_tos_inc;
        if (restore_v_i) begin
            w_tos_n   = restore_tos_i & ptr_mask_lp;
            w_count_n = (restore_count_i > cnt_max_lp) ? cnt_max_lp : restore_count_i;
        end else begin
            case (w_op)
                RAS_OP_SWAP: begin
                    wr_en_c_o  = 1'b1;
                    wr_idx_c_o = r_tos;
                    if (r_count == '0) w_count_n = cnt_width_lp'(1);
                end
                RAS_OP_PUSH: begin
                    wr_en_c_o  = 1'b1;
                    wr_idx_c_o = w_tos_inc;
                    w_tos_n    = w_tos_inc;
                    if (r_count == cnt_max_lp) w_overflow_n = 1'b1;
                    else                       w_count_n    = r_count + cnt_width_lp'(1);
                end
                RAS_OP_POP: begin
                    if (r_count != '0) begin
                        w_tos_n   = w_tos_dec;
                        w_count_n = r_count - cnt_width_lp'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign tos_o      = r_tos;
    assign count_o    = r_count;
    assign overflow_o = r_overflow;

endmodule

// File: rtl/bp_fe_ras_stack.sv
// Multi-entry circular return address stack with checkpoint/restore of its pointers.
// Entry storage lives here; pointer policy lives in bp_fe_ras_ptr.
module bp_fe_ras_stack
    import bp_fe_ras_stack_pkg::*;
#(
    parameter int unsigned vaddr_width_p = RAS_VADDR_W_DEF,
    parameter int unsigned ras_els_p     = RAS_ELS_DEF,
    parameter int unsigned ptr_width_lp  = safe_clog2(ras_els_p),
    parameter int unsigned cnt_width_lp  = $clog2(ras_els_p + 1),
    parameter int unsigned ckpt_width_lp = ptr_width_lp + cnt_width_lp
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     call_i,
    input  logic                     return_i,
    input  logic [vaddr_width_p-1:0] addr_i,
    output logic [vaddr_width_p-1:0] tgt_o,
    output logic                     v_o,
    output logic [ckpt_width_lp-1:0] ckpt_o,
    input  logic                     restore_v_i,
    input  logic [ckpt_width_lp-1:0] restore_ckpt_i,
    output logic                     overflow_o
);

    logic [vaddr_width_p-1:0] r_mem [ras_els_p];
    logic [ptr_width_lp-1:0]  w_tos, w_wr_idx;
    logic [cnt_width_lp-1:0]  w_count;
    logic                     w_wr_en;

    bp_fe_ras_ptr #(
        .ras_els_p    (ras_els_p),
        .ptr_width_lp (ptr_width_lp),
        .cnt_width_lp (cnt_width_lp)
    ) u_ptr (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .call_i          (call_i),
        .return_i        (return_i),
        .restore_v_i     (restore_v_i),
        .restore_tos_i   (restore_ckpt_i[ptr_width_lp-1:0]),
        .restore_count_i (restore_ckpt_i[ckpt_width_lp-1:ptr_width_lp]),
        .tos_o           (w_tos),
        .count_o         (w_count),
        .wr_idx_c_o      (w_wr_idx),
        .wr_en_c_o       (w_wr_en),
        .overflow_o      (overflow_o)
    );

    // Entries are never repaired on restore; stale wrong-path writes are tolerated
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < int'(ras_els_p); i++) r_mem[i] <= '0;
        end else if (w_wr_en) begin
            r_mem[w_wr_idx] <= addr_i;
        end
    end

    assign tgt_o  = r_mem[w_tos];
    assign v_o    = (w_count != '0);
    assign ckpt_o = {w_count, w_tos};

endmodule

// File: tb/tb_bp_fe_ras_stack.sv
// Self-checking bench for bp_fe_ras_stack: vector table through a scoreboard queue,
// plus a hand-written asynchronous mid-cycle reset sequence.
module tb_bp_fe_ras_stack;

    localparam int unsigned VW  = 39;
    localparam int unsigned ELS = 8;
    localparam int unsigned PW  = 3;
    localparam int unsigned CW  = 4;
    localparam int unsigned KW  = PW + CW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic          rv = 1'b0;
    logic [VW-1:0] addr = '0;
    logic [KW-1:0] rck = '0;
    logic [VW-1:0] tgt;
    logic          v;
    logic          ovf;
    logic [KW-1:0] ck;

    always #5 clk = ~clk;

    bp_fe_ras_stack #(
        .vaddr_width_p (VW),
        .ras_els_p     (ELS)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .call_i         (call),
        .return_i       (ret),
        .addr_i         (addr),
        .tgt_o          (tgt),
        .v_o            (v),
        .ckpt_o         (ck),
        .restore_v_i    (rv),
        .restore_ckpt_i (rck),
        .overflow_o     (ovf)
    );

    typedef struct {
        logic          call;
        logic          ret;
        logic          rv;
        logic [VW-1:0] addr;
        logic [KW-1:0] rck;
        logic [VW-1:0] e_tgt;
        logic          e_v;
        logic [KW-1:0] e_ck;
        logic          e_ovf;
    } vec_t;

    typedef struct {
        int            idx;
        logic [VW-1:0] tgt;
        logic          v;
        logic [KW-1:0] ck;
        logic          ovf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [KW-1:0] mk(input int c, input int t);
        return {CW'(c), PW'(t)};
    endfunction

    function automatic void add(input logic c, input logic r, input logic rsv,
                                input logic [VW-1:0] a, input logic [KW-1:0] rk,
                                input logic [VW-1:0] et, input logic ev,
                                input logic [KW-1:0] ek, input logic eo);
        vec_t t;
        t.call = c; t.ret = r; t.rv = rsv; t.addr = a; t.rck = rk;
        t.e_tgt = et; t.e_v = ev; t.e_ck = ek; t.e_ovf = eo;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        exp_t e;
        @(negedge clk);
        call = t.call; ret = t.ret; rv = t.rv; addr = t.addr; rck = t.rck;
        e.idx = idx; e.tgt = t.e_tgt; e.v = t.e_v; e.ck = t.e_ck; e.ovf = t.e_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard step %0d: got empty queue expected one entry", idx);
        end else begin
            e = sb.pop_front();
            chk("tgt_o", e.idx, 64'(tgt), 64'(e.tgt));
            chk("v_o", e.idx, 64'(v), 64'(e.v));
            chk("ckpt_o", e.idx, 64'(ck), 64'(e.ck));
            chk("overflow_o", e.idx, 64'(ovf), 64'(e.ovf));
        end
    endtask

    task automatic idle_inputs();
        call = 1'b0; ret = 1'b0; rv = 1'b0; addr = '0; rck = '0;
    endtask

    initial begin
        // Basic push/push/pop, then pops into and past empty
        add(1, 0, 0, 39'h1000, '0, 39'h1000, 1, mk(1, 1), 0);
        add(1, 0, 0, 39'h2000, '0, 39'h2000, 1, mk(2, 2), 0);
        add(0, 1, 0, '0,       '0, 39'h1000, 1, mk(1, 1), 0);
        add(0, 1, 0, '0,       '0, '0,       0, mk(0, 0), 0);
        add(0, 1, 0, '0,       '0, '0,       0, mk(0, 0), 0);
        // Nine pushes into an 8-deep stack; only the ninth overflows
        for (int k = 1; k <= 9; k++)
            add(1, 0, 0, VW'(k * 'h100), '0, VW'(k * 'h100), 1,
                mk((k > 8) ? 8 : k, k % 8), (k == 9));
        // Eight pops return 0x900 down to 0x200; the last leaves an empty stack
        for (int i = 1; i <= 8; i++)
            add(0, 1, 0, '0, '0, (i < 8) ? VW'((9 - i) * 'h100) : VW'('h900),
                (i < 8), mk(8 - i, (9 - i) % 8), 0);
        // Checkpoint at {3,3}, wrong-path activity, then restore
        add(0, 0, 1, '0,      mk(0, 0), 39'h800, 0, mk(0, 0), 0);
        add(1, 0, 0, 39'hA1,  '0,       39'hA1,  1, mk(1, 1), 0);
        add(1, 0, 0, 39'hA2,  '0,       39'hA2,  1, mk(2, 2), 0);
        add(1, 0, 0, 39'hA3,  '0,       39'hA3,  1, mk(3, 3), 0);
        add(1, 0, 0, 39'hB4,  '0,       39'hB4,  1, mk(4, 4), 0);
        add(1, 0, 0, 39'hB5,  '0,       39'hB5,  1, mk(5, 5), 0);
        add(0, 1, 0, '0,      '0,       39'hB4,  1, mk(4, 4), 0);
        add(0, 0, 1, '0,      mk(3, 3), 39'hA3,  1, mk(3, 3), 0);
        // Restore beats a simultaneous call; mem[4] must still hold B4
        add(1, 0, 1, 39'hC0,  mk(2, 2), 39'hA2,  1, mk(2, 2), 0);
        add(0, 0, 1, '0,      mk(4, 4), 39'hB4,  1, mk(4, 4), 0);
        // Call+return replaces the top without moving pointers
        add(0, 0, 1, '0,      mk(2, 2), 39'hA2,  1, mk(2, 2), 0);
        add(1, 1, 0, 39'hD0,  '0,       39'hD0,  1, mk(2, 2), 0);
        add(0, 1, 0, '0,      '0,       39'hA1,  1, mk(1, 1), 0);
        add(0, 1, 0, '0,      '0,       39'h800, 0, mk(0, 0), 0);
        add(1, 1, 0, 39'hE0,  '0,       39'hE0,  1, mk(1, 0), 0);
        // Out-of-range restored count clamps to depth
        add(0, 0, 1, '0, {4'd15, 3'd5}, 39'hB5,  1, mk(8, 5), 0);
        add(1, 1, 0, 39'hF0,  '0,       39'hF0,  1, mk(8, 5), 0);
        add(0, 1, 0, '0,      '0,       39'hB4,  1, mk(7, 4), 0);
        add(0, 0, 1, '0,      mk(5, 2), 39'hD0,  1, mk(5, 2), 0);

        #12;
        chk("reset_tgt_o", -1, 64'(tgt), 64'(0));
        chk("reset_v_o", -1, 64'(v), 64'(0));
        chk("reset_ckpt_o", -1, 64'(ck), 64'(0));
        chk("reset_overflow_o", -1, 64'(ovf), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;

        for (int n = 0; n < vecs.size(); n++) apply(vecs[n], n);
        idle_inputs();

        // Asynchronous reset between edges with count=5 clears outputs before the next edge
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_tgt_o", 100, 64'(tgt), 64'(0));
        chk("async_rst_v_o", 100, 64'(v), 64'(0));
        chk("async_rst_ckpt_o", 100, 64'(ck), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        begin
            vec_t t;
            t.call = 0; t.ret = 0; t.rv = 1; t.addr = '0; t.rck = mk(3, 3);
            t.e_tgt = '0; t.e_v = 1; t.e_ck = mk(3, 3); t.e_ovf = 0;
            apply(t, 101);
            t.call = 1; t.rv = 0; t.addr = 39'h7_0000_1234; t.rck = '0;
            t.e_tgt = 39'h7_0000_1234; t.e_ck = mk(4, 4);
            apply(t, 102);
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
